// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: moves a sprite once per synchronized VGA frame
// tick under keyboard control, bouncing off or wrapping around the screen edges.
module sprite_motion_ctrl #(
  parameter int W        = 10,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int SIZE     = 4,
  parameter int STEP     = 1,
  parameter int WRAP     = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         vs,
  input  logic [7:0]   keycode,
  output logic [W-1:0] BallX,
  output logic [W-1:0] BallY,
  output logic [W-1:0] BallS,
  output logic         moving,
  output logic         hit
);

  localparam int SW = W + 2;
  typedef logic signed [SW-1:0] sval_t;

  localparam sval_t ZERO   = '0;
  localparam sval_t ONE    = sval_t'(1);
  localparam sval_t STEP_S = sval_t'(STEP);
  localparam sval_t SIZE_S = sval_t'(SIZE);
  localparam sval_t XMAX_S = sval_t'(X_MAX);
  localparam sval_t YMAX_S = sval_t'(Y_MAX);
  localparam logic [W-1:0] SIZE_W = W'(SIZE);
  localparam logic [W-1:0] XC_W   = W'(X_CENTER);
  localparam logic [W-1:0] YC_W   = W'(Y_CENTER);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  typedef struct packed {
    logic [W-1:0] pos;
    sval_t        mot;
    logic         hit;
  } axis_t;

  // One axis of motion for a frame; bounce reverses motion before the move.
  function automatic axis_t step_axis(input logic [W-1:0] pos, input sval_t mot,
                                      input sval_t lim);
    sval_t p;
    sval_t m;
    sval_t n;
    axis_t r;
    p     = sval_t'({2'b00, pos});
    m     = mot;
    r.hit = 1'b0;
    if (WRAP != 0) begin
      n = p + m;
      if (n > lim) begin
        n     = n - (lim + ONE);
        r.hit = 1'b1;
      end else if (n < ZERO) begin
        n     = n + (lim + ONE);
        r.hit = 1'b1;
      end
    end else begin
      if ((m > ZERO) && (p + SIZE_S >= lim)) begin
        m     = -STEP_S;
        r.hit = 1'b1;
      end else if ((m < ZERO) && (p <= SIZE_S)) begin
        m     = STEP_S;
        r.hit = 1'b1;
      end
      n = p + m;
      if (n < ZERO)     n = ZERO;
      else if (n > lim) n = lim;
    end
    r.pos = n[W-1:0];
    r.mot = m;
    return r;
  endfunction

  state_t       state_q, state_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  sval_t        mx_q, mx_d, my_q, my_d;
  logic         moving_q, moving_d;
  logic         hit_q, hit_d;
  logic         vs_meta_q, vs_sync_q, vs_prev_q;
  logic         space_prev_q;

  logic  tick;
  logic  space_press;
  logic  key_dir;
  sval_t kmx, kmy, cmx, cmy;
  axis_t ax, ay;

  assign tick        = vs_sync_q & ~vs_prev_q;
  assign space_press = (keycode == 8'h2C) && !space_prev_q;

  always_comb begin
    key_dir = 1'b1;
    kmx     = ZERO;
    kmy     = ZERO;
    case (keycode)
      8'h1A:   kmy = -STEP_S;
      8'h16:   kmy = STEP_S;
      8'h04:   kmx = -STEP_S;
      8'h07:   kmx = STEP_S;
      default: key_dir = 1'b0;
    endcase
    cmx = key_dir ? kmx : mx_q;
    cmy = key_dir ? kmy : my_q;
    ax  = step_axis(x_q, cmx, XMAX_S);
    ay  = step_axis(y_q, cmy, YMAX_S);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mx_d    = mx_q;
    my_d    = my_q;
    hit_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && key_dir) begin
          state_d = RUN;
          x_d     = ax.pos;
          y_d     = ay.pos;
          mx_d    = ax.mot;
          my_d    = ay.mot;
          hit_d   = ax.hit | ay.hit;
        end
      end
      RUN: begin
        // A space press wins over a coincident tick: pause without moving.
        if (space_press) begin
          state_d = PAUSE;
        end else if (tick) begin
          x_d   = ax.pos;
          y_d   = ay.pos;
          mx_d  = ax.mot;
          my_d  = ay.mot;
          hit_d = ax.hit | ay.hit;
        end
      end
      PAUSE: begin
        if (space_press) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    moving_d = (state_d == RUN) && ((mx_d != ZERO) || (my_d != ZERO));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      x_q          <= XC_W;
      y_q          <= YC_W;
      mx_q         <= ZERO;
      my_q         <= ZERO;
      moving_q     <= 1'b0;
      hit_q        <= 1'b0;
      vs_meta_q    <= 1'b0;
      vs_sync_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      space_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      mx_q         <= mx_d;
      my_q         <= my_d;
      moving_q     <= moving_d;
      hit_q        <= hit_d;
      vs_meta_q    <= vs;
      vs_sync_q    <= vs_meta_q;
      vs_prev_q    <= vs_sync_q;
      space_prev_q <= (keycode == 8'h2C);
    end
  end

  assign BallX  = x_q;
  assign BallY  = y_q;
  assign BallS  = SIZE_W;
  assign moving = moving_q;
  assign hit    = hit_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: a bouncing and a wrapping instance share all
// stimulus and are both checked against a frame-level arithmetic model.
module tb_sprite_motion_ctrl;

  localparam int XMAX = 639;
  localparam int YMAX = 479;
  localparam int SZ   = 4;
  localparam int STP  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs  = 1'b0;
  logic [7:0] keycode = 8'h00;

  logic [9:0] bx0, by0, bs0, bx1, by1, bs1;
  logic       mv0, mv1, hit0, hit1;

  logic [9:0] obx[2];
  logic [9:0] oby[2];
  logic [9:0] obs[2];
  logic       omv[2];
  logic       oht[2];
  assign obx[0] = bx0;  assign obx[1] = bx1;
  assign oby[0] = by0;  assign oby[1] = by1;
  assign obs[0] = bs0;  assign obs[1] = bs1;
  assign omv[0] = mv0;  assign omv[1] = mv1;
  assign oht[0] = hit0; assign oht[1] = hit1;

  sprite_motion_ctrl #(.WRAP(0)) u_bounce (
    .Clk(clk), .Reset(rst), .vs(vs), .keycode(keycode),
    .BallX(bx0), .BallY(by0), .BallS(bs0), .moving(mv0), .hit(hit0)
  );

  sprite_motion_ctrl #(.WRAP(1)) u_wrap (
    .Clk(clk), .Reset(rst), .vs(vs), .keycode(keycode),
    .BallX(bx1), .BallY(by1), .BallS(bs1), .moving(mv1), .hit(hit1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance; st: 0 idle, 1 run, 2 pause
  int px[2], py[2], mx[2], my[2], st[2], hm[2];
  int wrapm[2];
  logic [7:0] last_key;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      px[i] = 320; py[i] = 240; mx[i] = 0; my[i] = 0; st[i] = 0; hm[i] = 0;
    end
    wrapm[0] = 0;
    wrapm[1] = 1;
    last_key = 8'h00;
  endtask

  task automatic model_space();
    for (int i = 0; i < 2; i++) begin
      if (st[i] == 1)      st[i] = 2;
      else if (st[i] == 2) st[i] = 1;
    end
  endtask

  task automatic model_axis(inout int p, inout int m, input int lim, input int wrap,
                            inout int h);
    if (wrap != 0) begin
      p = p + m;
      if (p > lim)    begin p = p - (lim + 1); h = 1; end
      else if (p < 0) begin p = p + (lim + 1); h = 1; end
    end else begin
      if (m > 0 && p + SZ >= lim) begin m = -STP; h = 1; end
      else if (m < 0 && p <= SZ)  begin m = STP;  h = 1; end
      p = p + m;
      if (p < 0)   p = 0;
      if (p > lim) p = lim;
    end
  endtask

  task automatic model_tick(input logic [7:0] k);
    int dx, dy;
    bit isdir;
    isdir = 1;
    dx = 0;
    dy = 0;
    case (k)
      8'h1A:   dy = -STP;
      8'h16:   dy = STP;
      8'h04:   dx = -STP;
      8'h07:   dx = STP;
      default: isdir = 0;
    endcase
    for (int i = 0; i < 2; i++) begin
      hm[i] = 0;
      if (st[i] == 2) continue;
      if (st[i] == 0 && !isdir) continue;
      st[i] = 1;
      if (isdir) begin mx[i] = dx; my[i] = dy; end
      model_axis(px[i], mx[i], XMAX, wrapm[i], hm[i]);
      model_axis(py[i], my[i], YMAX, wrapm[i], hm[i]);
    end
  endtask

  function automatic logic exp_moving(input int i);
    return (st[i] == 1) && (mx[i] != 0 || my[i] != 0);
  endfunction

  // One frame: set key, raise vs, check pre-tick, tick and post-tick cycles.
  task automatic frame(input logic [7:0] k);
    @(negedge clk);
    keycode = k;
    if (k == 8'h2C && last_key != 8'h2C) model_space();
    last_key = k;
    @(negedge clk);
    vs = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obx[i] !== 10'(px[i]) || oby[i] !== 10'(py[i]) ||
          omv[i] !== exp_moving(i) || oht[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL pre_tick[%0d]: got x=%0d y=%0d mv=%b hit=%b, want x=%0d y=%0d mv=%b hit=0",
                 i, obx[i], oby[i], omv[i], oht[i], px[i], py[i], exp_moving(i));
      end
    end
    @(posedge clk);
    #1;
    model_tick(k);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obx[i] !== 10'(px[i]) || oby[i] !== 10'(py[i])) begin
        n_fail++;
        $display("FAIL pos[%0d]: got x=%0d y=%0d, want x=%0d y=%0d",
                 i, obx[i], oby[i], px[i], py[i]);
      end
      n_checks++;
      if (omv[i] !== exp_moving(i) || oht[i] !== hm[i][0]) begin
        n_fail++;
        $display("FAIL flags[%0d]: got mv=%b hit=%b, want mv=%b hit=%0d",
                 i, omv[i], oht[i], exp_moving(i), hm[i]);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (oht[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL hit_width[%0d]: got hit=%b, want 0", i, oht[i]);
      end
    end
    @(negedge clk);
    vs = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    keycode = 8'h00;
    vs = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obx[i] !== 10'd320 || oby[i] !== 10'd240 || omv[i] !== 1'b0 ||
          oht[i] !== 1'b0 || obs[i] !== 10'd4) begin
        n_fail++;
        $display("FAIL reset[%0d]: got x=%0d y=%0d s=%0d mv=%b hit=%b, want 320 240 4 0 0",
                 i, obx[i], oby[i], obs[i], omv[i], oht[i]);
      end
    end
    repeat (3) frame(8'h00);
    n_checks++;
    if (bx0 !== 10'd320 || by0 !== 10'd240 || mv0 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got x=%0d y=%0d mv=%b, want 320 240 0", bx0, by0, mv0);
    end
  endtask

  task automatic test_run_right();
    repeat (5) frame(8'h07);
    n_checks++;
    if (bx0 !== 10'd325 || by0 !== 10'd240 || mv0 !== 1'b1) begin
      n_fail++;
      $display("FAIL run5: got x=%0d y=%0d mv=%b, want 325 240 1", bx0, by0, mv0);
    end
    repeat (2) frame(8'h00);
    n_checks++;
    if (bx0 !== 10'd327) begin
      n_fail++;
      $display("FAIL retain: got x=%0d, want 327", bx0);
    end
  endtask

  task automatic test_pause();
    repeat (3) frame(8'h07);
    frame(8'h2C);
    repeat (4) frame(8'h00);
    n_checks++;
    if (bx0 !== 10'd330 || mv0 !== 1'b0) begin
      n_fail++;
      $display("FAIL paused: got x=%0d mv=%b, want 330 0", bx0, mv0);
    end
    frame(8'h2C);
    n_checks++;
    if (bx0 !== 10'd331 || mv0 !== 1'b1) begin
      n_fail++;
      $display("FAIL resume: got x=%0d mv=%b, want 331 1", bx0, mv0);
    end
  endtask

  task automatic test_space_at_tick();
    frame(8'h00);
    @(negedge clk);
    vs = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    keycode = 8'h2C;
    model_space();
    last_key = 8'h2C;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obx[i] !== 10'(px[i]) || omv[i] !== 1'b0 || oht[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL space_tick[%0d]: got x=%0d mv=%b hit=%b, want x=%0d mv=0 hit=0",
                 i, obx[i], omv[i], oht[i], px[i]);
      end
    end
    @(negedge clk);
    vs = 1'b0;
    repeat (3) @(posedge clk);
    frame(8'h00);
    frame(8'h2C);
  endtask

  task automatic test_edges();
    repeat (340) frame(8'h07);
    repeat (250) frame(8'h1A);
    repeat (20) frame(8'h00);
  endtask

  task automatic test_random();
    logic [7:0] keys[6] = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C};
    logic [7:0] k;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) k = 8'($urandom);
      else                           k = keys[$urandom_range(0, 5)];
      frame(k);
    end
  endtask

  task automatic test_reset_tick();
    apply_reset();
    repeat (80) frame(8'h07);
    n_checks++;
    if (bx0 !== 10'd400 || bx1 !== 10'd400) begin
      n_fail++;
      $display("FAIL reach400: got x0=%0d x1=%0d, want 400 400", bx0, bx1);
    end
    @(negedge clk);
    vs = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obx[i] !== 10'd320 || oby[i] !== 10'd240 || omv[i] !== 1'b0 || oht[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_tick[%0d]: got x=%0d y=%0d mv=%b hit=%b, want 320 240 0 0",
                 i, obx[i], oby[i], omv[i], oht[i]);
      end
    end
    @(negedge clk);
    vs = 1'b0;
    keycode = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    frame(8'h2C);
    frame(8'h07);
    n_checks++;
    if (bx0 !== 10'd321 || mv0 !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_reset: got x=%0d mv=%b, want 321 1", bx0, mv0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_right();
    test_pause();
    test_space_at_tick();
    test_edges();
    test_random();
    test_reset_tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
